// File: rtl/truth_table_probe.sv
// truth_table_probe: applies all 16 input vectors to a 4-input circuit and reads back
// its truth table (vector 0 lands in the MSB), flagging samples that disagree.
module truth_table_probe #(
   parameter int SETTLE_CYCLES = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic [15:0] expected,
   output logic        tt_in1,
   output logic        tt_in2,
   output logic        tt_in3,
   output logic        tt_in4,
   input  logic        tt_out,
   output logic        busy,
   output logic        done,
   output logic [15:0] truth_table,
   output logic        match,
   output logic        unstable
);

   localparam int CW = $clog2(SETTLE_CYCLES + 1);
   localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE_CYCLES - 1);
   localparam logic [2:0] IDLE     = 3'd0;
   localparam logic [2:0] SETTLE   = 3'd1;
   localparam logic [2:0] SAMPLE_A = 3'd2;
   localparam logic [2:0] SAMPLE_B = 3'd3;
   localparam logic [2:0] DONE     = 3'd4;

   generate
      if (SETTLE_CYCLES < 2 || SETTLE_CYCLES > 255) begin : g_range_check
         $error("SETTLE_CYCLES must lie in 2..255");
      end
   endgenerate

   logic [2:0]    state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [3:0]    idx_q, idx_d;
   logic [1:0]    sync_q, sync_d;
   logic          samp_a_q, samp_a_d;
   logic [15:0]   sr_q, sr_d;
   logic          unst_acc_q, unst_acc_d;
   logic [15:0]   exp_q, exp_d;
   logic [15:0]   tt_q, tt_d;
   logic          match_q, match_d;
   logic          unstable_q, unstable_d;
   logic          done_q, done_d;

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      idx_d      = idx_q;
      sync_d     = {sync_q[0], tt_out};
      samp_a_d   = samp_a_q;
      sr_d       = sr_q;
      unst_acc_d = unst_acc_q;
      exp_d      = exp_q;
      tt_d       = tt_q;
      match_d    = match_q;
      unstable_d = unstable_q;
      done_d     = 1'b0;
      case (state_q)
         IDLE: begin
            if (start) begin
               state_d    = SETTLE;
               cnt_d      = '0;
               idx_d      = '0;
               sr_d       = '0;
               unst_acc_d = 1'b0;
               exp_d      = expected;
            end
         end
         SETTLE: begin
            if (cnt_q == SETTLE_LAST) state_d = SAMPLE_A;
            else cnt_d = cnt_q + 1'b1;
         end
         SAMPLE_A: begin
            samp_a_d = sync_q[1];
            state_d  = SAMPLE_B;
         end
         SAMPLE_B: begin
            sr_d       = {sr_q[14:0], sync_q[1]};
            unst_acc_d = unst_acc_q | (samp_a_q ^ sync_q[1]);
            cnt_d      = '0;
            // Results commit here so done and the new table appear on the same edge.
            if (idx_q == 4'hF) begin
               state_d    = DONE;
               tt_d       = sr_d;
               match_d    = (sr_d == exp_q);
               unstable_d = unst_acc_d;
               done_d     = 1'b1;
            end else begin
               idx_d   = idx_q + 4'd1;
               state_d = SETTLE;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         idx_q      <= '0;
         sync_q     <= '0;
         samp_a_q   <= 1'b0;
         sr_q       <= '0;
         unst_acc_q <= 1'b0;
         exp_q      <= '0;
         tt_q       <= '0;
         match_q    <= 1'b0;
         unstable_q <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         idx_q      <= idx_d;
         sync_q     <= sync_d;
         samp_a_q   <= samp_a_d;
         sr_q       <= sr_d;
         unst_acc_q <= unst_acc_d;
         exp_q      <= exp_d;
         tt_q       <= tt_d;
         match_q    <= match_d;
         unstable_q <= unstable_d;
         done_q     <= done_d;
      end
   end

   assign {tt_in1, tt_in2, tt_in3, tt_in4} = idx_q;
   assign busy        = (state_q == SETTLE) || (state_q == SAMPLE_A) || (state_q == SAMPLE_B);
   assign done        = done_q;
   assign truth_table = tt_q;
   assign match       = match_q;
   assign unstable    = unstable_q;

endmodule

// File: tb/tb_truth_table_probe.sv
// tb_truth_table_probe: table-driven sweeps against modelled circuits, plus handshake,
// mid-sweep reset and short-settle sequences on a second instance.
module tb_truth_table_probe;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic        start1 = 1'b0, start2 = 1'b0;
   logic [15:0] exp1 = '0, exp2 = '0;
   logic        a1, a2, a3, a4, b1, b2, b3, b4;
   logic        tt_out1, tt_out2;
   logic        busy1, busy2, done1, done2;
   logic [15:0] tt1, tt2;
   logic        match1, match2, unst1, unst2;
   logic [3:0]  vec1, vec2;
   logic [3:0]  h1 = '0, h2 = '0, h3 = '0;
   int          mode1 = 0, mode2 = 0;
   int          cyc = 0;
   int          ndone = 0;
   int          errors = 0, checks = 0;

   truth_table_probe #(.SETTLE_CYCLES(4)) u_dut (
      .clk(clk), .rst_n(rst_n), .start(start1), .expected(exp1),
      .tt_in1(a1), .tt_in2(a2), .tt_in3(a3), .tt_in4(a4), .tt_out(tt_out1),
      .busy(busy1), .done(done1), .truth_table(tt1), .match(match1), .unstable(unst1)
   );

   truth_table_probe #(.SETTLE_CYCLES(2)) u_dut2 (
      .clk(clk), .rst_n(rst_n), .start(start2), .expected(exp2),
      .tt_in1(b1), .tt_in2(b2), .tt_in3(b3), .tt_in4(b4), .tt_out(tt_out2),
      .busy(busy2), .done(done2), .truth_table(tt2), .match(match2), .unstable(unst2)
   );

   assign vec1 = {a1, a2, a3, a4};
   assign vec2 = {b1, b2, b3, b4};

   // v = {in1,in2,in3,in4}
   function automatic logic golden(input logic [3:0] v);
      return (v[1] & v[0]) ? v[3] : v[1] ? ~v[2] : ~(v[3] & v[2]);
   endfunction

   function automatic logic cut(input int m, input logic [3:0] v);
      case (m)
         1:       return v[3];
         2:       return v[0];
         3:       return 1'b0;
         default: return golden(v);
      endcase
   endfunction

   // Mode 4 inverts the output only while sample B of vector 5 is being taken.
   assign tt_out1 = cut(mode1, vec1) ^ (mode1 == 4 && cyc >= 33 && cyc < 36);
   assign tt_out2 = (mode2 == 1) ? golden(h3) : golden(vec2);

   always @(posedge clk) begin
      cyc <= (start1 && !busy1) ? 0 : cyc + 1;
      h1  <= vec2;
      h2  <= h1;
      h3  <= h2;
   end

   always @(negedge clk) if (done1) ndone <= ndone + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic sweep(input bit sel, input logic [15:0] e, output int n);
      @(negedge clk);
      if (sel) begin start2 = 1'b1; exp2 = e; end
      else begin start1 = 1'b1; exp1 = e; end
      @(posedge clk);
      @(negedge clk);
      start1 = 1'b0;
      start2 = 1'b0;
      exp1 = ~e;
      exp2 = ~e;
      chk("busy_after_start", sel ? busy2 : busy1, 1);
      chk("vec0_applied", sel ? vec2 : vec1, 0);
      n = 0;
      while (!(sel ? done2 : done1) && n < 300) begin
         @(negedge clk);
         n++;
      end
      chk("busy_low_at_done", sel ? busy2 : busy1, 0);
      chk("last_vec_held", sel ? vec2 : vec1, 15);
   endtask

   typedef struct {
      int          mode;
      logic [15:0] exp_in;
      logic [15:0] tt;
      logic        m;
      logic        u;
   } vec_t;

   vec_t tv[6];

   initial begin
      int n, d0;
      tv[0] = '{0, 16'hECF1, 16'hECF1, 1'b1, 1'b0};
      tv[1] = '{1, 16'hFFFF, 16'h00FF, 1'b0, 1'b0};
      tv[2] = '{2, 16'hFFFF, 16'h5555, 1'b0, 1'b0};
      tv[3] = '{3, 16'hFFFF, 16'h0000, 1'b0, 1'b0};
      tv[4] = '{4, 16'hECF1, 16'hE8F1, 1'b0, 1'b1};
      tv[5] = '{1, 16'h00FF, 16'h00FF, 1'b1, 1'b0};

      repeat (3) @(negedge clk);
      chk("rst_vec", vec1, 0);
      chk("rst_busy", busy1, 0);
      chk("rst_done", done1, 0);
      chk("rst_tt", tt1, 0);
      chk("rst_match", match1, 0);
      chk("rst_unstable", unst1, 0);
      chk("rst_busy2", busy2, 0);
      chk("rst_tt2", tt2, 0);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      for (int i = 0; i < 6; i++) begin
         mode1 = tv[i].mode;
         sweep(1'b0, tv[i].exp_in, n);
         chk("done_cycle", n, 96);
         chk("truth_table", tt1, tv[i].tt);
         chk("match", match1, tv[i].m);
         chk("unstable", unst1, tv[i].u);
      end

      // Starts at cycle 40 and in the done cycle are ignored; the one after is taken.
      mode1 = 0;
      @(negedge clk);
      start1 = 1'b1;
      exp1 = 16'hECF1;
      @(posedge clk);
      @(negedge clk);
      start1 = 1'b0;
      n = 0;
      d0 = ndone;
      while (n < 40) begin @(negedge clk); n++; end
      start1 = 1'b1;
      @(negedge clk);
      n++;
      start1 = 1'b0;
      while (!done1 && n < 300) begin @(negedge clk); n++; end
      chk("hs_done_cycle", n, 96);
      start1 = 1'b1;
      @(negedge clk);
      chk("hs_done_cycle_start_ignored", busy1, 0);
      @(posedge clk);
      @(negedge clk);
      start1 = 1'b0;
      chk("hs_restart_busy", busy1, 1);
      n = 0;
      while (!done1 && n < 300) begin @(negedge clk); n++; end
      chk("hs_second_done_cycle", n, 96);
      chk("hs_second_tt", tt1, 16'hECF1);
      @(negedge clk);
      #1;
      chk("hs_done_count", ndone - d0, 2);

      // Asynchronous reset in the middle of a sweep.
      @(negedge clk);
      start1 = 1'b1;
      exp1 = 16'hECF1;
      @(posedge clk);
      @(negedge clk);
      start1 = 1'b0;
      n = 0;
      while (n < 50) begin @(negedge clk); n++; end
      #1 rst_n = 1'b0;
      #1;
      chk("mid_rst_vec", vec1, 0);
      chk("mid_rst_busy", busy1, 0);
      chk("mid_rst_done", done1, 0);
      chk("mid_rst_tt", tt1, 0);
      chk("mid_rst_match", match1, 0);
      chk("mid_rst_unstable", unst1, 0);
      d0 = ndone;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (100) @(negedge clk);
      #1;
      chk("no_done_after_reset", ndone - d0, 0);
      sweep(1'b0, 16'hECF1, n);
      chk("post_rst_done_cycle", n, 96);
      chk("post_rst_tt", tt1, 16'hECF1);
      chk("post_rst_match", match1, 1);

      // Two-cycle settle window: golden passes, a 3-cycle-late circuit reads the previous vector.
      mode2 = 0;
      sweep(1'b1, 16'hECF1, n);
      chk("s2_done_cycle", n, 64);
      chk("s2_tt", tt2, 16'hECF1);
      chk("s2_match", match2, 1);
      mode2 = 1;
      repeat (4) @(negedge clk);
      sweep(1'b1, 16'hECF1, n);
      chk("s2_slow_done_cycle", n, 64);
      chk("s2_slow_tt", tt2, 16'hF678);
      chk("s2_slow_match", match2, 0);
      chk("s2_slow_unstable", unst2, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/truth_table_probe.md
# truth_table_probe

Sequential characterizer for 4-input NOR/NOT logic blocks. It drives all 16 input combinations into a circuit-under-test and waits a programmable settle time after each one. It samples the circuit's output and assembles the 16-bit hex truth table in the same encoding the designs are named by (e.g. a 0xECF1 design reads back 16'hECF1). It sits beside each generated design in the bench and regression fabric, and is the read-back end of the truth-table → gate-netlist flow.

## Interface
- SETTLE_CYCLES, default 4: clock cycles between applying a vector and the first sample, including the 2-flop synchronizer. Legal range 2..255; out-of-range values fail elaboration.
- clk  in  1  sole clock, rising edge.
- rst_n  in  1  reset. Asynchronous and active-low.
- start  in  1  one-cycle request to begin a sweep. Ignored while busy=1.
- expected  in  16  reference truth table, captured on the accepted start edge.
- tt_in1, tt_in2, tt_in3, tt_in4  out  1 each  drive the circuit-under-test inputs in1..in4.
- tt_out  in  1  circuit-under-test output; may be asynchronous.
- busy  out  1  high from the accepted start through the final sample.
- done  out  1  one-cycle pulse when a sweep completes.
- truth_table  out  16  last completed result. Held until the next done.
- match  out  1  registered (truth_table == captured expected), updated with done.
- unstable  out  1  set at done if any vector's two samples disagreed.

## Operation
- Vector index i = {tt_in1, tt_in2, tt_in3, tt_in4}, with tt_in1 as MSB. Index runs 0→15.
- The output for index i lands in truth_table[15-i]; index 0 is the MSB.
- tt_out passes through a 2-flop synchronizer; all samples are taken from its output.
- FSM states:
  - IDLE → SETTLE on an accepted start. Clear the index, the settle counter, the shift register and the unstable accumulator; capture expected.
  - SETTLE counts SETTLE_CYCLES-1 cycles, then → SAMPLE_A.
  - SAMPLE_A latches sample A → SAMPLE_B.
  - SAMPLE_B latches sample B and shifts B into the result. If A≠B, set the unstable accumulator.
    - i<15: increment i and → SETTLE.
    - i==15: → DONE.
  - DONE commits truth_table, match and unstable, pulses done, clears busy → IDLE.
- The settle counter is $clog2(SETTLE_CYCLES+1) bits wide. The index is a 4-bit counter and never wraps: the sweep stops at 15.
- tt_in* hold the last vector (15 = 4'b1111) after a sweep until the next start, which returns them to 0.
- start while busy (including the DONE cycle) is ignored. start in IDLE on the cycle after done is accepted.
- expected changing mid-sweep has no effect.
- Reset, including mid-sweep: FSM → IDLE and the synchronizer is cleared. No done pulse is emitted and previous results are lost.

## Timing
- Reset values: tt_in*=0, busy=0, done=0, truth_table=16'h0000, match=0, unstable=0.
- Accepted start on edge E0: busy=1 and vector 0 is applied at E0.
- Vector i is applied at E0 + i·(SETTLE_CYCLES+2).
- For vector i, sample A is taken at edge +SETTLE_CYCLES and sample B at +SETTLE_CYCLES+1, both relative to the vector's apply edge. The next vector is applied on the edge after sample B.
- done is high for the cycle starting at E0 + 16·(SETTLE_CYCLES+2). With the default, that is 96 cycles after start.
- truth_table, match and unstable change only on that same edge.
- busy falls on the same edge that raises done.
- The circuit-under-test combinational delay plus synchronizer must fit within SETTLE_CYCLES; the integrator sets SETTLE_CYCLES accordingly.

## Test plan
- Golden design: tt_out = ~(in1&in2) when in3&in4=0 and in3=0; ~in2 when in3=1,in4=0; in1 when in3=in4=1. Start with expected=16'hECF1 → done at cycle 96, truth_table=16'hECF1, match=1, unstable=0.
- Buffers: tt_out=tt_in1 → 16'h00FF. tt_out=tt_in4 → 16'h5555. Constant 0 → 16'h0000. With expected=16'hFFFF → match=0 each time.
- Glitch: toggle tt_out between samples A and B for vector 5 only → unstable=1; truth_table bit 10 equals sample B.
- Handshake: pulse start at cycles 1, 40 and the done cycle → only the first is accepted; exactly one done pulse. A start one cycle after done launches a second sweep whose done comes 96 cycles later.
- Reset mid-sweep: assert rst_n=0 at cycle 50 → all outputs 0 immediately (asynchronous) and no done. A new start after release yields the correct result.
- SETTLE_CYCLES=2: done at cycle 64. A circuit whose tt_out transitions are delayed 3 cycles produces mismatches, proving the settle window is honoured.
